pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the stall and flush inputs of the IFID, IDEX, EXMEM and MEMWB pipeline registers and the PC write enable. It resolves load-use hazards, taken-branch redirects, multi-cycle data-memory waits and a halt drain sequence. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 106 ++++++++++
 rtl/hazard_sat_counter.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pipeline_ctrl_pkg
//  Description : Shared types, constants and control-bundle helpers for the
//                five-stage pipeline stall/flush controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  // Controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  // Number of cycles spent draining after a halt reaches MEM
  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_W      = 2;

  // PC enable plus the stall/flush pair of every pipeline register
  typedef struct packed {
    logic pc_write;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic exmem_flush;
    logic memwb_stall;
    logic memwb_flush;
  } ctrl_t;

  // Free-running pipeline: PC advances, nothing held or flushed
  function automatic ctrl_t ctrl_pass();
    ctrl_t c;
    c = '0;
    c.pc_write = 1'b1;
    return c;
  endfunction

  // Hold IF..EXMEM, bubble into MEMWB while data memory is busy
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c = '0;
    c.ifid_stall  = 1'b1;
    c.idex_stall  = 1'b1;
    c.exmem_stall = 1'b1;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

  // Halt/drain: stop fetch, let EXMEM and MEMWB retire their contents
  function automatic ctrl_t ctrl_drain();
    ctrl_t c;
    c = '0;
    c.ifid_stall  = 1'b1;
    c.idex_flush  = 1'b1;
    c.exmem_flush = 1'b1;
    return c;
  endfunction

  // Taken branch: keep fetching from the new target, kill two wrong-path slots
  function automatic ctrl_t ctrl_redirect();
    ctrl_t c;
    c = '0;
    c.pc_write   = 1'b1;
    c.ifid_flush = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Load-use: hold the consumer in ID for one cycle, bubble into EX
  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c = '0;
    c.ifid_stall = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Terminal halt: every register held
  function automatic ctrl_t ctrl_halted();
    ctrl_t c;
    c = '0;
    c.ifid_stall  = 1'b1;
    c.idex_stall  = 1'b1;
    c.exmem_stall = 1'b1;
    c.memwb_stall = 1'b1;
    return c;
  endfunction

  // Reset: flush every stage so the pipe restarts empty
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c = '0;
    c.ifid_flush  = 1'b1;
    c.idex_flush  = 1'b1;
    c.exmem_flush = 1'b1;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sat_counter
//  Description : Saturating up-counter with synchronous clear and enable.
//                Clear together with enable loads 1 so the clearing cycle can
//                itself be counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: reset, clear/load-1, or saturating increment
  always_comb begin
    count_d = count_q;
    if (rst) begin
      count_d = '0;
    end else if (clr) begin
      count_d = en ? WIDTH'(1) : '0;
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central stall/flush controller for the five-stage pipeline.
//                Resolves load-use, redirect, data-memory wait and halt drain;
//                keeps a saturating stall counter and a sticky timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFIDRs1,
  input  logic [4:0]       IFIDRs2,
  input  logic             IFIDUsesRs1,
  input  logic             IFIDUsesRs2,
  input  logic             IDEXMemRead,
  input  logic [4:0]       IDEXRegRd,
  input  logic             EXBranchTaken,
  input  logic             EXMEMMemReq,
  input  logic             DMemReady,
  input  logic             EXMEMHalt,
  output logic             PCWrite,
  output logic             IFIDStall,
  output logic             IFIDFlush,
  output logic             IDEXStall,
  output logic             IDEXFlush,
  output logic             EXMEMStall,
  output logic             EXMEMFlush,
  output logic             MEMWBStall,
  output logic             MEMWBFlush,
  output logic             Halted,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_clr, wait_en;
  logic                stall_en;
  logic                mem_wait, load_use;
  ctrl_t               run_ctrl, ctrl;
  state_e              run_next;

  assign mem_wait = EXMEMMemReq && !DMemReady;
  assign load_use = IDEXMemRead && (IDEXRegRd != 5'd0) &&
                    ((IFIDUsesRs1 && (IFIDRs1 == IDEXRegRd)) ||
                     (IFIDUsesRs2 && (IFIDRs2 == IDEXRegRd)));

  // Normal-operation priority (memory wait handled by the caller)
  always_comb begin
    run_ctrl = ctrl_pass();
    run_next = ST_RUN;
    if (EXMEMHalt) begin
      run_ctrl = ctrl_drain();
      run_next = ST_DRAIN;
    end else if (EXBranchTaken) begin
      run_ctrl = ctrl_redirect();
    end else if (load_use) begin
      run_ctrl = ctrl_load_use();
    end
  end

  // Controller FSM: next state, counter controls and pipeline controls
  always_comb begin
    ctrl          = ctrl_pass();
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    mem_timeout_d = mem_timeout_q;
    wait_clr      = 1'b1;
    wait_en       = 1'b0;
    if (rst) begin
      ctrl          = ctrl_reset();
      state_d       = ST_RUN;
      drain_cnt_d   = '0;
      mem_timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          drain_cnt_d = '0;
          if (mem_wait) begin
            ctrl    = ctrl_freeze();
            state_d = ST_MEMWAIT;
            wait_en = 1'b1;          // clear+enable loads 1
          end else begin
            ctrl    = run_ctrl;
            state_d = run_next;
          end
        end
        ST_MEMWAIT: begin
          drain_cnt_d = '0;
          if (DMemReady) begin
            ctrl    = run_ctrl;
            state_d = run_next;
          end else if (wait_cnt == TIMEOUT_VAL) begin
            // Give up on the access: flag it and let the pipe move on
            ctrl          = run_ctrl;
            state_d       = run_next;
            mem_timeout_d = 1'b1;
          end else begin
            ctrl     = ctrl_freeze();
            wait_clr = 1'b0;
            wait_en  = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (mem_wait) begin
            ctrl = ctrl_freeze();    // drain pauses while memory is busy
          end else begin
            ctrl = ctrl_drain();
            if (drain_cnt_q == DRAIN_LAST) begin
              state_d = ST_HALTED;
            end else begin
              drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
            end
          end
        end
        ST_HALTED: begin
          ctrl = ctrl_halted();
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State, drain counter and sticky timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      drain_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_en = !rst && !ctrl.pc_write && (state_q != ST_HALTED);

  hazard_sat_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (wait_clr),
    .en    (wait_en),
    .count (wait_cnt)
  );

  hazard_sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (stall_en),
    .count (StallCount)
  );

  assign PCWrite    = ctrl.pc_write;
  assign IFIDStall  = ctrl.ifid_stall;
  assign IFIDFlush  = ctrl.ifid_flush;
  assign IDEXStall  = ctrl.idex_stall;
  assign IDEXFlush  = ctrl.idex_flush;
  assign EXMEMStall = ctrl.exmem_stall;
  assign EXMEMFlush = ctrl.exmem_flush;
  assign MEMWBStall = ctrl.memwb_stall;
  assign MEMWBFlush = ctrl.memwb_flush;
  assign Halted     = !rst && (state_q == ST_HALTED);
  assign MemTimeout = mem_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl: vector table,
//                directed multi-cycle sequences and random stimulus against a
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 8;
  localparam int SMAX = (1 << CW) - 1;

  // Expected control vectors {PC, IFID s/f, IDEX s/f, EXMEM s/f, MEMWB s/f}
  localparam logic [8:0] V_RST  = 9'b0_01_01_01_01;
  localparam logic [8:0] V_NONE = 9'b1_00_00_00_00;
  localparam logic [8:0] V_LU   = 9'b0_10_01_00_00;
  localparam logic [8:0] V_BR   = 9'b1_01_01_00_00;
  localparam logic [8:0] V_HALT = 9'b0_10_01_01_00;
  localparam logic [8:0] V_FRZ  = 9'b0_10_10_10_01;
  localparam logic [8:0] V_HLTD = 9'b0_10_10_10_10;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] IFIDRs1, IFIDRs2, IDEXRegRd;
  logic IFIDUsesRs1, IFIDUsesRs2, IDEXMemRead, EXBranchTaken;
  logic EXMEMMemReq, DMemReady, EXMEMHalt;
  logic PCWrite, IFIDStall, IFIDFlush, IDEXStall, IDEXFlush;
  logic EXMEMStall, EXMEMFlush, MEMWBStall, MEMWBFlush;
  logic Halted, MemTimeout;
  logic [CW-1:0] StallCount;
  logic [8:0] act_ctl;

  assign act_ctl = {PCWrite, IFIDStall, IFIDFlush, IDEXStall, IDEXFlush,
                    EXMEMStall, EXMEMFlush, MEMWBStall, MEMWBFlush};

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IFIDRs1       (IFIDRs1),
    .IFIDRs2       (IFIDRs2),
    .IFIDUsesRs1   (IFIDUsesRs1),
    .IFIDUsesRs2   (IFIDUsesRs2),
    .IDEXMemRead   (IDEXMemRead),
    .IDEXRegRd     (IDEXRegRd),
    .EXBranchTaken (EXBranchTaken),
    .EXMEMMemReq   (EXMEMMemReq),
    .DMemReady     (DMemReady),
    .EXMEMHalt     (EXMEMHalt),
    .PCWrite       (PCWrite),
    .IFIDStall     (IFIDStall),
    .IFIDFlush     (IFIDFlush),
    .IDEXStall     (IDEXStall),
    .IDEXFlush     (IDEXFlush),
    .EXMEMStall    (EXMEMStall),
    .EXMEMFlush    (EXMEMFlush),
    .MEMWBStall    (MEMWBStall),
    .MEMWBFlush    (MEMWBFlush),
    .Halted        (Halted),
    .MemTimeout    (MemTimeout),
    .StallCount    (StallCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: what the pipeline is currently doing
  bit m_waiting  = 0;   // a data access is outstanding
  bit m_draining = 0;
  bit m_halted   = 0;
  bit m_to       = 0;
  int m_waited   = 0;   // cycles the outstanding access has already waited
  int m_drained  = 0;   // drain cycles already completed
  int m_stalls   = 0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic       halt;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [8:0] ctl;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    IFIDRs1 = v.rs1; IFIDRs2 = v.rs2; IFIDUsesRs1 = v.u1; IFIDUsesRs2 = v.u2;
    IDEXMemRead = v.mr; IDEXRegRd = v.rd; EXBranchTaken = v.br;
    EXMEMMemReq = v.req; DMemReady = v.rdy; EXMEMHalt = v.halt;
  endtask

  function automatic logic [8:0] run_rule();
    bit lu;
    lu = IDEXMemRead && (IDEXRegRd != 0) &&
         ((IFIDUsesRs1 && IFIDRs1 == IDEXRegRd) || (IFIDUsesRs2 && IFIDRs2 == IDEXRegRd));
    if (EXMEMHalt)     return V_HALT;
    if (EXBranchTaken) return V_BR;
    if (lu)            return V_LU;
    return V_NONE;
  endfunction

  // Expected {controls, Halted} for the current model state and inputs
  function automatic logic [9:0] model_out();
    bit mw;
    mw = EXMEMMemReq && !DMemReady;
    if (rst)        return {V_RST, 1'b0};
    if (m_halted)   return {V_HLTD, 1'b1};
    if (m_draining) return {(mw ? V_FRZ : V_HALT), 1'b0};
    if (m_waiting)  return {((!DMemReady && m_waited < TO) ? V_FRZ : run_rule()), 1'b0};
    return {(mw ? V_FRZ : run_rule()), 1'b0};
  endfunction

  task automatic model_commit(input bit pc);
    bit mw;
    mw = EXMEMMemReq && !DMemReady;
    if (rst) begin
      m_waiting = 0; m_draining = 0; m_halted = 0; m_to = 0;
      m_waited = 0; m_drained = 0; m_stalls = 0;
    end else if (!m_halted) begin
      if (!pc) m_stalls = (m_stalls < SMAX) ? m_stalls + 1 : SMAX;
      if (m_draining) begin
        if (!mw) begin
          m_drained++;
          if (m_drained == 2) begin m_draining = 0; m_halted = 1; end
        end
      end else if (m_waiting && !DMemReady && m_waited < TO) begin
        m_waited++;
      end else begin
        if (m_waiting && !DMemReady) m_to = 1;
        if (!m_waiting && mw) begin
          m_waiting = 1; m_waited = 1;
        end else begin
          m_waiting = 0;
          if (EXMEMHalt) begin m_draining = 1; m_drained = 0; end
        end
      end
    end
  endtask

  // One clock: check against the model, take the edge, update the model
  task automatic cycle();
    logic [9:0] e;
    #2;
    e = model_out();
    chk("ctl", {act_ctl, Halted}, e);
    chk("stallcount", StallCount, m_stalls);
    chk("memtimeout", MemTimeout, m_to);
    @(posedge clk);
    model_commit(e[9]);
    @(negedge clk);
  endtask

  task automatic rand_inputs(input bit allow_rst);
    in_t v;
    v.rs1  = 5'($urandom_range(0, 7));
    v.rs2  = 5'($urandom_range(0, 7));
    v.rd   = 5'($urandom_range(0, 7));
    v.u1   = 1'($urandom_range(0, 1));
    v.u2   = 1'($urandom_range(0, 1));
    v.mr   = 1'($urandom_range(0, 1));
    v.br   = ($urandom_range(0, 4) == 0);
    v.req  = ($urandom_range(0, 2) == 0);
    v.rdy  = 1'($urandom_range(0, 1));
    v.halt = ($urandom_range(0, 24) == 0);
    drive(v);
    rst = allow_rst && ($urandom_range(0, 59) == 0);
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  vec_t vt[11];

  initial begin
    //            rs1   rs2   u1 u2 mr rd    br req rdy halt   expected
    vt[0]  = '{'{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0}, V_NONE};
    vt[1]  = '{'{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0}, V_LU};
    vt[2]  = '{'{5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, 0}, V_NONE};
    vt[3]  = '{'{5'd1, 5'd9, 1, 1, 1, 5'd9, 0, 0, 0, 0}, V_LU};
    vt[4]  = '{'{5'd9, 5'd1, 0, 1, 1, 5'd9, 0, 0, 0, 0}, V_NONE};
    vt[5]  = '{'{5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0}, V_BR};
    vt[6]  = '{'{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1}, V_HALT};
    vt[7]  = '{'{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, 0}, V_FRZ};
    vt[8]  = '{'{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1}, V_FRZ};
    vt[9]  = '{'{5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 1, 1, 0}, V_LU};
    vt[10] = '{'{5'd7, 5'd7, 1, 1, 0, 5'd7, 0, 0, 0, 0}, V_NONE};

    drive('0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state: forced outputs, counters zero
    cycle();
    rst = 1'b0;

    // Vector table, each applied from a freshly reset RUN state
    for (int k = 0; k < 11; k++) begin
      do_reset();
      drive(vt[k].i);
      #1;
      chk($sformatf("vec%0d", k), act_ctl, vt[k].ctl);
      cycle();
    end

    // Load-use: one bubble, StallCount 0 -> 1
    do_reset();
    drive('{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0});
    chk("lu_cnt_before", StallCount, 0);
    cycle();
    drive('0);
    chk("lu_cnt_after", StallCount, 1);
    cycle();

    // Memory wait: 3 frozen cycles, release on the 4th
    do_reset();
    drive('{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, 0});
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mw_frz%0d", k), act_ctl, V_FRZ);
      cycle();
    end
    DMemReady = 1'b1;
    #1;
    chk("mw_release", act_ctl, V_BR);
    cycle();
    chk("mw_cnt", StallCount, 3);
    drive('0);
    cycle();

    // Timeout: DMemReady held low, flag rises after TO wait cycles
    do_reset();
    drive('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0});
    for (int k = 0; k < TO; k++) cycle();
    chk("to_before", MemTimeout, 0);
    cycle();
    chk("to_set", MemTimeout, 1);
    for (int k = 0; k < 6; k++) begin
      DMemReady = ~DMemReady;
      cycle();
    end
    chk("to_sticky", MemTimeout, 1);
    do_reset();
    chk("to_cleared", MemTimeout, 0);

    // Halt: 2 drain cycles then HALTED, immune to inputs until reset
    do_reset();
    drive('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1});
    cycle();
    drive('0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("drain%0d", k), {act_ctl, Halted}, {V_HALT, 1'b0});
      cycle();
    end
    #1;
    chk("halted", {act_ctl, Halted}, {V_HLTD, 1'b1});
    chk("halt_cnt", StallCount, 3);
    for (int k = 0; k < 8; k++) begin
      rand_inputs(1'b0);
      cycle();
    end
    #1;
    chk("halted_stays", Halted, 1);
    do_reset();
    chk("halt_rst_cnt", StallCount, 0);
    chk("halt_rst_run", Halted, 0);

    // Reset in the middle of a memory wait
    drive('{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0});
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", act_ctl, V_RST);
    cycle();
    rst = 1'b0;
    EXMEMMemReq = 1'b0;
    #1;
    chk("mid_rst_run", act_ctl, V_NONE);
    cycle();

    // Saturation of the stall counter under a persistent load-use
    do_reset();
    drive('{5'd2, 5'd0, 1, 0, 1, 5'd2, 0, 0, 0, 0});
    for (int k = 0; k < SMAX + 40; k++) cycle();
    chk("sat_cnt", StallCount, SMAX);

    // Random stimulus against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rand_inputs(1'b1);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
